// File: rtl/ex_stage.sv
// RV32 execute stage: single-cycle ALU plus optional iterative RV32M unit.
// Define EX_MD_EN to build the multiply/divide FSM; otherwise codes 16-23 return 0.
module ex_stage #(
   parameter int CTRL_W  = 5,
   parameter int ALUOP_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               valid_ex,
   input  logic               flush,
   input  logic [CTRL_W-1:0]  ctrl_ex,
   input  logic [ALUOP_W-1:0] alu_op,
   input  logic [31:0]        op_a,
   input  logic [31:0]        op_b,
   input  logic [31:0]        store_data,
   input  logic [31:0]        pc4_ex,
   input  logic [31:0]        rd_ex,
   output logic               stall_ex,
   output logic               valid_mem,
   output logic [CTRL_W-1:0]  ctrl_mem,
   output logic [31:0]        rd_mem,
   output logic [31:0]        pc4_mem,
   output logic [31:0]        alu_result,
   output logic [31:0]        write_data1
);

   localparam logic [ALUOP_W-1:0] OP_ADD   = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] OP_SUB   = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] OP_SLL   = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] OP_SLT   = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] OP_SLTU  = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] OP_XOR   = ALUOP_W'(5);
   localparam logic [ALUOP_W-1:0] OP_SRL   = ALUOP_W'(6);
   localparam logic [ALUOP_W-1:0] OP_SRA   = ALUOP_W'(7);
   localparam logic [ALUOP_W-1:0] OP_OR    = ALUOP_W'(8);
   localparam logic [ALUOP_W-1:0] OP_AND   = ALUOP_W'(9);
   localparam logic [ALUOP_W-1:0] OP_PASSB = ALUOP_W'(10);

   logic [4:0]  shamt;
   logic [31:0] alu_res, ex_result;

   assign shamt = op_b[4:0];

   always_comb begin
      alu_res = '0;
      case (alu_op)
         OP_ADD:   alu_res = op_a + op_b;
         OP_SUB:   alu_res = op_a - op_b;
         OP_SLL:   alu_res = op_a << shamt;
         OP_SLT:   alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
         OP_SLTU:  alu_res = {31'b0, op_a < op_b};
         OP_XOR:   alu_res = op_a ^ op_b;
         OP_SRL:   alu_res = op_a >> shamt;
         OP_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
         OP_OR:    alu_res = op_a | op_b;
         OP_AND:   alu_res = op_a & op_b;
         OP_PASSB: alu_res = op_b;
         default:  alu_res = '0;
      endcase
   end

`ifdef EX_MD_EN
   localparam logic [ALUOP_W-1:0] OP_MUL    = ALUOP_W'(16);
   localparam logic [ALUOP_W-1:0] OP_MULH   = ALUOP_W'(17);
   localparam logic [ALUOP_W-1:0] OP_MULHSU = ALUOP_W'(18);
   localparam logic [ALUOP_W-1:0] OP_DIV    = ALUOP_W'(20);
   localparam logic [ALUOP_W-1:0] OP_REM    = ALUOP_W'(22);
   localparam logic [ALUOP_W-1:0] OP_REMU   = ALUOP_W'(23);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nx;

   // p holds {acc, multiplier} for mul and {remainder, quotient} for div
   logic [63:0] p, p_step, prod;
   logic [31:0] b_r, abs_a, abs_b, md_res;
   logic [32:0] mul_sum, div_sh, div_df;
   logic [2:0]  op_r;
   logic [4:0]  cnt;
   logic        neg_r, md_op, is_div, is_rem, sgn_a, sgn_b;
   logic        div_zero, div_ovf, md_start, div_ge;

   assign md_op    = (alu_op >= OP_MUL) && (alu_op <= OP_REMU);
   assign is_div   = alu_op[2];
   assign is_rem   = alu_op[2] & alu_op[1];
   assign sgn_a    = op_a[31] & (alu_op == OP_MULH || alu_op == OP_MULHSU ||
                                 alu_op == OP_DIV  || alu_op == OP_REM);
   assign sgn_b    = op_b[31] & (alu_op == OP_MULH || alu_op == OP_DIV || alu_op == OP_REM);
   assign abs_a    = sgn_a ? -op_a : op_a;
   assign abs_b    = sgn_b ? -op_b : op_b;
   assign div_zero = is_div && (op_b == 32'd0);
   assign div_ovf  = (alu_op == OP_DIV || alu_op == OP_REM) &&
                     (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
   assign md_start = valid_ex & md_op & ~flush;
   assign stall_ex = valid_ex & md_op & ~flush & (state != DONE);

   assign mul_sum = {1'b0, p[63:32]} + (p[0] ? {1'b0, b_r} : 33'd0);
   assign div_sh  = {p[63:32], p[31]};
   assign div_ge  = div_sh >= {1'b0, b_r};
   assign div_df  = div_sh - {1'b0, b_r};
   assign p_step  = op_r[2] ? {(div_ge ? div_df[31:0] : div_sh[31:0]), p[30:0], div_ge}
                            : {mul_sum, p[31:1]};

   always_comb begin
      state_nx = state;
      if (flush) state_nx = IDLE;
      else begin
         case (state)
            IDLE:    if (md_start) state_nx = (div_zero || div_ovf) ? DONE : BUSY;
            BUSY:    if (cnt == 5'd31) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Special cases preload the final answer with neg_r=0 so DONE needs no extra path
   always_ff @(posedge clk) begin
      if (reset) begin
         p     <= '0;
         b_r   <= '0;
         op_r  <= '0;
         neg_r <= 1'b0;
         cnt   <= '0;
      end else if (state == IDLE && md_start) begin
         op_r <= alu_op[2:0];
         cnt  <= '0;
         if (div_zero) begin
            p     <= {op_a, 32'hFFFF_FFFF};
            neg_r <= 1'b0;
         end else if (div_ovf) begin
            p     <= {32'h0, 32'h8000_0000};
            neg_r <= 1'b0;
         end else begin
            p     <= {32'h0, abs_a};
            b_r   <= abs_b;
            neg_r <= is_rem ? sgn_a : (sgn_a ^ sgn_b);
         end
      end else if (state == BUSY) begin
         p   <= p_step;
         cnt <= cnt + 5'd1;
      end
   end

   assign prod = neg_r ? -p : p;

   always_comb begin
      md_res = '0;
      case (op_r)
         3'd0:       md_res = prod[31:0];
         3'd4, 3'd5: md_res = prod[31:0];
         3'd6, 3'd7: md_res = neg_r ? -p[63:32] : p[63:32];
         default:    md_res = prod[63:32];
      endcase
   end

   assign ex_result = md_op ? md_res : alu_res;
`else
   assign stall_ex  = 1'b0;
   assign ex_result = alu_res;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_mem   <= 1'b0;
         ctrl_mem    <= '0;
         rd_mem      <= '0;
         pc4_mem     <= '0;
         alu_result  <= '0;
         write_data1 <= '0;
      end else if (valid_ex && !stall_ex && !flush) begin
         valid_mem   <= 1'b1;
         ctrl_mem    <= ctrl_ex;
         rd_mem      <= rd_ex;
         pc4_mem     <= pc4_ex;
         alu_result  <= ex_result;
         write_data1 <= store_data;
      end else begin
         valid_mem <= 1'b0;
         ctrl_mem  <= '0;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU vector table, bubbles, and mul/div sequences when EX_MD_EN is set.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        reset, valid_ex, flush;
   logic [4:0]  ctrl_ex, alu_op;
   logic [31:0] op_a, op_b, store_data, pc4_ex, rd_ex;
   logic        stall_ex, valid_mem;
   logic [4:0]  ctrl_mem;
   logic [31:0] rd_mem, pc4_mem, alu_result, write_data1;

   int n_vec = 0;
   int n_err = 0;

   ex_stage #(.CTRL_W(5), .ALUOP_W(5)) dut (
      .clk(clk), .reset(reset), .valid_ex(valid_ex), .flush(flush),
      .ctrl_ex(ctrl_ex), .alu_op(alu_op), .op_a(op_a), .op_b(op_b),
      .store_data(store_data), .pc4_ex(pc4_ex), .rd_ex(rd_ex),
      .stall_ex(stall_ex), .valid_mem(valid_mem), .ctrl_mem(ctrl_mem),
      .rd_mem(rd_mem), .pc4_mem(pc4_mem), .alu_result(alu_result),
      .write_data1(write_data1)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } alu_vec_t;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          stall;
   } md_vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      alu_op   = op;
      op_a     = a;
      op_b     = b;
      valid_ex = 1'b1;
   endtask

`ifdef EX_MD_EN
   task automatic run_md(input string nm, input md_vec_t v);
      int   n;
      logic bub;
      n   = 0;
      bub = 1'b0;
      drive(v.op, v.a, v.b);
      #1;
      while (stall_ex && n < 100) begin
         n++;
         @(negedge clk);
         bub = bub | valid_mem;
         #1;
      end
      chk({nm, "_stall"}, 32'(n), 32'(v.stall));
      chk({nm, "_bubble"}, {31'b0, bub}, 32'd0);
      @(negedge clk);
      valid_ex = 1'b0;
      chk({nm, "_res"}, alu_result, v.exp);
      chk({nm, "_vld"}, {31'b0, valid_mem}, 32'd1);
   endtask
`endif

   alu_vec_t av[14];
`ifdef EX_MD_EN
   md_vec_t  mv[18];
`endif

   initial begin
      av[0]  = '{5'd0,  32'hFFFF_FFFF, 32'd1,        32'd0};
      av[1]  = '{5'd1,  32'd5,         32'd7,        32'hFFFF_FFFE};
      av[2]  = '{5'd2,  32'd1,         32'h23,       32'd8};
      av[3]  = '{5'd3,  32'hFFFF_FFFF, 32'd1,        32'd1};
      av[4]  = '{5'd3,  32'd1,         32'hFFFF_FFFF, 32'd0};
      av[5]  = '{5'd4,  32'd1,         32'hFFFF_FFFF, 32'd1};
      av[6]  = '{5'd5,  32'hF0F0,      32'hFF00,     32'h0FF0};
      av[7]  = '{5'd6,  32'h8000_0000, 32'd4,        32'h0800_0000};
      av[8]  = '{5'd7,  32'h8000_0000, 32'd4,        32'hF800_0000};
      av[9]  = '{5'd8,  32'hF0,        32'h0F,       32'hFF};
      av[10] = '{5'd9,  32'hF0,        32'h3C,       32'h30};
      av[11] = '{5'd11, 32'd5,         32'd6,        32'd0};
      av[12] = '{5'd31, 32'd5,         32'd6,        32'd0};
      av[13] = '{5'd10, 32'd5,         32'h1234,     32'h1234};
`ifdef EX_MD_EN
      mv[0]  = '{5'd16, 32'hFFFF_FFFF, 32'd3,        32'hFFFF_FFFD, 33};
      mv[1]  = '{5'd19, 32'hFFFF_FFFF, 32'd3,        32'h0000_0002, 33};
      mv[2]  = '{5'd17, 32'hFFFF_FFFF, 32'd3,        32'hFFFF_FFFF, 33};
      mv[3]  = '{5'd18, 32'hFFFF_FFFF, 32'd3,        32'hFFFF_FFFF, 33};
      mv[4]  = '{5'd17, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
      mv[5]  = '{5'd18, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 33};
      mv[6]  = '{5'd19, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33};
      mv[7]  = '{5'd20, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33};
      mv[8]  = '{5'd22, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33};
      mv[9]  = '{5'd20, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
      mv[10] = '{5'd22, 32'd7,         32'hFFFF_FFFE, 32'd1,        33};
      mv[11] = '{5'd21, 32'd100,       32'd7,        32'd14,       33};
      mv[12] = '{5'd23, 32'd100,       32'd7,        32'd2,        33};
      mv[13] = '{5'd20, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF, 1};
      mv[14] = '{5'd22, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 1};
      mv[15] = '{5'd21, 32'd5,         32'd0,        32'hFFFF_FFFF, 1};
      mv[16] = '{5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      mv[17] = '{5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1};
`endif

      // Reset held two edges with a live ADD waiting in ID/EX
      reset = 1'b1; flush = 1'b0;
      ctrl_ex = 5'b01111; rd_ex = 32'd20; pc4_ex = 32'd56; store_data = 32'hCAFE;
      drive(5'd0, 32'd40, 32'd8);
      repeat (2) @(negedge clk);
      chk("rst_vld",  {31'b0, valid_mem}, 32'd0);
      chk("rst_ctrl", 32'(ctrl_mem), 32'd0);
      chk("rst_rd",   rd_mem, 32'd0);
      chk("rst_pc4",  pc4_mem, 32'd0);
      chk("rst_res",  alu_result, 32'd0);
      chk("rst_wd",   write_data1, 32'd0);

      reset = 1'b0;
      @(negedge clk);
      chk("add_res",  alu_result, 32'd48);
      chk("add_ctrl", 32'(ctrl_mem), 32'b01111);
      chk("add_rd",   rd_mem, 32'd20);
      chk("add_pc4",  pc4_mem, 32'd56);
      chk("add_wd",   write_data1, 32'hCAFE);
      chk("add_vld",  {31'b0, valid_mem}, 32'd1);

      for (int i = 0; i < 14; i++) begin
         ctrl_ex = 5'b10001;
         rd_ex   = 32'(i);
         drive(av[i].op, av[i].a, av[i].b);
         #1;
         chk($sformatf("alu%0d_stall", i), {31'b0, stall_ex}, 32'd0);
         @(negedge clk);
         chk($sformatf("alu%0d_res", i), alu_result, av[i].exp);
         chk($sformatf("alu%0d_rd", i), rd_mem, 32'(i));
      end

      // Bubble: control cleared, data held
      valid_ex = 1'b0;
      drive(5'd0, 32'd1, 32'd1);
      valid_ex = 1'b0;
      @(negedge clk);
      chk("bub_vld",  {31'b0, valid_mem}, 32'd0);
      chk("bub_ctrl", 32'(ctrl_mem), 32'd0);
      chk("bub_res",  alu_result, 32'h1234);
      chk("bub_rd",   rd_mem, 32'd13);

      drive(5'd0, 32'd1, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush1_vld", {31'b0, valid_mem}, 32'd0);
      chk("flush1_res", alu_result, 32'h1234);

`ifdef EX_MD_EN
      ctrl_ex = 5'b00011;
      for (int i = 0; i < 18; i++) run_md($sformatf("md%0d", i), mv[i]);

      // Flush in the tenth BUSY cycle
      drive(5'd16, 32'hFFFF_FFFF, 32'd3);
      repeat (10) @(negedge clk);
      #1;
      chk("mdfl_pre_stall", {31'b0, stall_ex}, 32'd1);
      flush = 1'b1;
      #1;
      chk("mdfl_stall", {31'b0, stall_ex}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      chk("mdfl_vld",  {31'b0, valid_mem}, 32'd0);
      chk("mdfl_ctrl", 32'(ctrl_mem), 32'd0);
      drive(5'd0, 32'd2, 32'd3);
      @(negedge clk);
      valid_ex = 1'b0;
      chk("mdfl_add", alu_result, 32'd5);
      chk("mdfl_add_vld", {31'b0, valid_mem}, 32'd1);

      // Reset in the fifth BUSY cycle
      drive(5'd20, 32'hFFFF_FFF9, 32'd2);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      valid_ex = 1'b0;
      chk("mdrst_vld",  {31'b0, valid_mem}, 32'd0);
      chk("mdrst_ctrl", 32'(ctrl_mem), 32'd0);
      chk("mdrst_res",  alu_result, 32'd0);
      chk("mdrst_rd",   rd_mem, 32'd0);
      chk("mdrst_pc4",  pc4_mem, 32'd0);
      chk("mdrst_wd",   write_data1, 32'd0);
      #1;
      chk("mdrst_stall", {31'b0, stall_ex}, 32'd0);
      run_md("mdrst_next", '{5'd21, 32'd100, 32'd7, 32'd14, 33});
`else
      // Without the M unit, 16-23 are unknown codes: result 0, latency 1, no stall
      for (int i = 16; i < 24; i++) begin
         drive(5'(i), 32'd3, 32'd3);
         #1;
         chk($sformatf("nomd%0d_stall", i), {31'b0, stall_ex}, 32'd0);
         @(negedge clk);
         chk($sformatf("nomd%0d_res", i), alu_result, 32'd0);
         chk($sformatf("nomd%0d_vld", i), {31'b0, valid_mem}, 32'd1);
      end
      valid_ex = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
